keypad_emulator: RTL and testbench

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_pkg.sv | 43 ++++
 rtl/key_fifo.sv | 76 +++++++
 rtl/keypad_emulator.sv | 237 +++++++++++++++++++++++
 tb/tb_keypad_emulator.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad emulator: FSM states, key_code field
// positions and the row/column line encodings.
package keypad_pkg;

  // Emulation FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_PRESS = 2'd2,
    ST_GAP   = 2'd3
  } kp_state_e;

  // Key request and line widths
  localparam int unsigned KEY_W  = 4;
  localparam int unsigned LINE_W = 4;

  // key_code field positions: [3:2] row index, [1:0] column index
  localparam int unsigned ROW_HI = 3;
  localparam int unsigned ROW_LO = 2;
  localparam int unsigned COL_HI = 1;
  localparam int unsigned COL_LO = 0;

  // Line encodings (all lines active-low)
  localparam logic [LINE_W-1:0] IDLE_LINES     = 4'b1111;
  localparam logic [LINE_W-1:0] SCAN_START_ROW = 4'b1110;
  localparam logic [LINE_W-1:0] LINE_ONE       = 4'b0001;

  // One-cold line pattern that pulls line 'idx' low
  function automatic logic [LINE_W-1:0] line_drive(input logic [1:0] idx);
    return ~(LINE_ONE << idx);
  endfunction

  // Row index field of a key code
  function automatic logic [1:0] key_row(input logic [KEY_W-1:0] code);
    return code[ROW_HI:ROW_LO];
  endfunction

  // Column index field of a key code
  function automatic logic [1:0] key_col(input logic [KEY_W-1:0] code);
    return code[COL_HI:COL_LO];
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous request FIFO. Full/empty come from the registered occupancy
// count, so a pop never makes a full FIFO accept in the same cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module key_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_q == DEPTH_CNT);
  assign empty     = (count_q == (AW+1)'(0));
  assign pop_data  = mem_q[rd_ptr_q];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Next storage, pointer and occupancy values
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_ok_s && !pop_ok_s) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop_ok_s && !push_ok_s) begin
      count_d = count_q - (AW+1)'(1);
    end else begin
      count_d = count_q;
    end
  end

  // FIFO state registers with synchronous reset to empty
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= (AW+1)'(0);
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// Keypad emulator: replays queued key codes onto a scanned matrix keypad by
// pulling the matching column low while the scanner drives the key's row.
// Each key is held for HOLD_SCANS scan rounds, followed by GAP_SCANS released
// rounds; a stalled scanner aborts the active key after TIMEOUT_CYCLES.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned HOLD_SCANS     = 3,
  parameter int unsigned GAP_SCANS      = 2,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [LINE_W-1:0] keyPad_row,
  output logic [LINE_W-1:0] keyPad_col,
  input  logic              key_valid,
  input  logic [KEY_W-1:0]  key_code,
  output logic              key_ready,
  output logic              key_done,
  output logic              timeout_err,
  output logic              busy
);

  localparam int unsigned RND_MAX = (HOLD_SCANS > GAP_SCANS) ? HOLD_SCANS : GAP_SCANS;
  localparam int unsigned RND_W   = (RND_MAX > 0) ? $clog2(RND_MAX + 1) : 1;
  localparam int unsigned TMO_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [RND_W-1:0] RND_SAT   = {RND_W{1'b1}};
  localparam logic [TMO_W-1:0] TMO_SAT   = {TMO_W{1'b1}};
  localparam logic [RND_W-1:0] HOLD_CNT  = RND_W'(HOLD_SCANS);
  localparam logic [RND_W-1:0] GAP_CNT   = RND_W'(GAP_SCANS);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  kp_state_e         state_q, state_d;
  logic [LINE_W-1:0] row_q, row_d;
  logic [LINE_W-1:0] row_prev_q, row_prev_d;
  logic [KEY_W-1:0]  cur_key_q, cur_key_d;
  logic [RND_W-1:0]  rnd_q, rnd_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              key_done_q, key_done_d;
  logic              timeout_err_q, timeout_err_d;

  logic              scan_start_s;
  logic [RND_W-1:0]  rnd_inc_s;
  logic [TMO_W-1:0]  tmo_inc_s;
  logic              tmo_hit_s;
  logic              hold_hit_s;
  logic              gap_hit_s;
  logic              fifo_pop_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [KEY_W-1:0]  fifo_head_s;

  // Pending key requests; the FIFO itself drops pushes while full
  key_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (key_valid),
    .push_data (key_code),
    .pop       (fifo_pop_s),
    .pop_data  (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // A round starts when the registered row first shows the top row active
  assign scan_start_s = (row_q == SCAN_START_ROW) && (row_prev_q != SCAN_START_ROW);

  // Saturating increments: counters stick at all-ones instead of wrapping
  assign rnd_inc_s  = (rnd_q == RND_SAT) ? RND_SAT : (rnd_q + RND_W'(1));
  assign tmo_inc_s  = (tmo_q == TMO_SAT) ? TMO_SAT : (tmo_q + TMO_W'(1));
  assign tmo_hit_s  = !scan_start_s && (tmo_inc_s == TMO_LIMIT);
  assign hold_hit_s = scan_start_s && (rnd_inc_s == HOLD_CNT);
  assign gap_hit_s  = scan_start_s && (rnd_inc_s == GAP_CNT);

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a timeout wins over round progress in every active state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          state_d = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (tmo_hit_s) begin
          state_d = ST_IDLE;
        end else if (scan_start_s) begin
          state_d = ST_PRESS;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_PRESS: begin
        if (tmo_hit_s) begin
          state_d = ST_IDLE;
        end else if (hold_hit_s) begin
          state_d = ST_GAP;
        end else begin
          state_d = ST_PRESS;
        end
      end
      ST_GAP: begin
        if (tmo_hit_s || gap_hit_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: column drive, FIFO pop and status flags
  always_comb begin
    keyPad_col = IDLE_LINES;
    if ((state_q == ST_PRESS) && (keyPad_row == line_drive(key_row(cur_key_q)))) begin
      keyPad_col = line_drive(key_col(cur_key_q));
    end else begin
      keyPad_col = IDLE_LINES;
    end
    fifo_pop_s  = (state_q == ST_IDLE) && !fifo_empty_s;
    busy        = (state_q != ST_IDLE) || !fifo_empty_s;
    key_ready   = !fifo_full_s;
    key_done    = key_done_q;
    timeout_err = timeout_err_q;
  end

  // Next values for the row history, current key, counters and event pulses
  always_comb begin
    row_d         = keyPad_row;
    row_prev_d    = row_q;
    cur_key_d     = cur_key_q;
    rnd_d         = rnd_q;
    tmo_d         = tmo_q;
    key_done_d    = 1'b0;
    timeout_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Counters sit at zero so ARM always starts with a fresh timeout window
        rnd_d = RND_W'(0);
        tmo_d = TMO_W'(0);
        if (!fifo_empty_s) begin
          cur_key_d = fifo_head_s;
        end else begin
          cur_key_d = cur_key_q;
        end
      end
      ST_ARM: begin
        if (tmo_hit_s) begin
          timeout_err_d = 1'b1;
          rnd_d         = RND_W'(0);
          tmo_d         = TMO_W'(0);
        end else if (scan_start_s) begin
          rnd_d = RND_W'(0);
          tmo_d = TMO_W'(0);
        end else begin
          tmo_d = tmo_inc_s;
        end
      end
      ST_PRESS: begin
        if (tmo_hit_s) begin
          timeout_err_d = 1'b1;
          rnd_d         = RND_W'(0);
          tmo_d         = TMO_W'(0);
        end else if (hold_hit_s) begin
          rnd_d = RND_W'(0);
          tmo_d = TMO_W'(0);
        end else if (scan_start_s) begin
          rnd_d = rnd_inc_s;
          tmo_d = TMO_W'(0);
        end else begin
          tmo_d = tmo_inc_s;
        end
      end
      ST_GAP: begin
        if (tmo_hit_s) begin
          timeout_err_d = 1'b1;
          rnd_d         = RND_W'(0);
          tmo_d         = TMO_W'(0);
        end else if (gap_hit_s) begin
          key_done_d = 1'b1;
          rnd_d      = RND_W'(0);
          tmo_d      = TMO_W'(0);
        end else if (scan_start_s) begin
          rnd_d = rnd_inc_s;
          tmo_d = TMO_W'(0);
        end else begin
          tmo_d = tmo_inc_s;
        end
      end
      default: begin
        rnd_d = RND_W'(0);
        tmo_d = TMO_W'(0);
      end
    endcase
  end

  // Datapath registers; reset parks the row history at the idle pattern
  always_ff @(posedge clock) begin
    if (reset) begin
      row_q         <= IDLE_LINES;
      row_prev_q    <= IDLE_LINES;
      cur_key_q     <= KEY_W'(0);
      rnd_q         <= RND_W'(0);
      tmo_q         <= TMO_W'(0);
      key_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      row_q         <= row_d;
      row_prev_q    <= row_prev_d;
      cur_key_q     <= cur_key_d;
      rnd_q         <= rnd_d;
      tmo_q         <= tmo_d;
      key_done_q    <= key_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: directed scenarios plus a random
// phase, all compared cycle by cycle against a key-level behavioural model.
module tb_keypad_emulator;

  localparam int HOLD  = 3;
  localparam int GAP   = 2;
  localparam int DEPTH = 4;
  localparam int TMO   = 100;

  logic       clock;
  logic       reset;
  logic [3:0] keyPad_row;
  logic [3:0] keyPad_col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       key_done;
  logic       timeout_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  keypad_emulator #(
    .HOLD_SCANS     (HOLD),
    .GAP_SCANS      (GAP),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .keyPad_row  (keyPad_row),
    .keyPad_col  (keyPad_col),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .key_done    (key_done),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Key-level reference model: one counter of scan starts seen since the key
  // was taken; starts 1..HOLD are the pressed rounds, the key finishes on
  // start 1+HOLD+GAP, and TMO start-free cycles abort it.
  logic [3:0] m_fifo[$];
  bit         m_active;
  logic [3:0] m_cur;
  int         m_starts;
  int         m_idle;
  logic [3:0] m_r1, m_r2;
  bit         m_done, m_terr;

  // Scanner and observation state
  bit         scan_on;
  logic [3:0] scan_ph;
  int         bad_rate;
  bit         force_en;
  logic [3:0] force_row;
  int         obs_done, obs_terr, obs_col;
  bit         seen_0, seen_f;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit ss;
    bit push_ok;
    if (reset) begin
      m_fifo.delete();
      m_active = 1'b0;
      m_starts = 0;
      m_idle   = 0;
      m_r1     = 4'hF;
      m_r2     = 4'hF;
      m_done   = 1'b0;
      m_terr   = 1'b0;
    end else begin
      ss      = (m_r1 == 4'b1110) && (m_r2 != 4'b1110);
      push_ok = key_valid && (m_fifo.size() < DEPTH);
      m_done  = 1'b0;
      m_terr  = 1'b0;
      if (!m_active) begin
        if (m_fifo.size() > 0) begin
          m_cur    = m_fifo.pop_front();
          m_active = 1'b1;
          m_starts = 0;
          m_idle   = 0;
        end
      end else begin
        if (ss) begin
          m_starts++;
          m_idle = 0;
        end else begin
          m_idle++;
        end
        if (ss && m_starts == 1 + HOLD + GAP) begin
          m_done   = 1'b1;
          m_active = 1'b0;
        end else if (m_idle == TMO) begin
          m_terr   = 1'b1;
          m_active = 1'b0;
        end
      end
      if (push_ok) m_fifo.push_back(key_code);
      m_r2 = m_r1;
      m_r1 = keyPad_row;
    end
  endtask

  task automatic check_outputs();
    logic [3:0] exp_col;
    logic [3:0] rowv;
    bit         press;
    rowv    = keyPad_row;
    exp_col = 4'hF;
    press   = m_active && (m_starts >= 1) && (m_starts <= HOLD);
    if (press && ($countones(rowv) == 3) && (rowv[m_cur[3:2]] == 1'b0)) exp_col[m_cur[1:0]] = 1'b0;
    chk("col", keyPad_col, exp_col);
    chk("ready", {3'b000, key_ready}, {3'b000, (m_fifo.size() < DEPTH)});
    chk("busy", {3'b000, busy}, {3'b000, (m_active || m_fifo.size() > 0)});
    chk("done", {3'b000, key_done}, {3'b000, m_done});
    chk("timeout", {3'b000, timeout_err}, {3'b000, m_terr});
    if (key_done === 1'b1) obs_done++;
    if (timeout_err === 1'b1) obs_terr++;
    if (keyPad_col !== 4'hF) obs_col++;
    if (keyPad_row == 4'b1110 && keyPad_col == 4'b1110) seen_0 = 1'b1;
    if (keyPad_row == 4'b0111 && keyPad_col == 4'b0111) seen_f = 1'b1;
  endtask

  // One clock: apply inputs, advance model on the edge, check on the falling edge
  task automatic cycle(input logic v, input logic [3:0] c);
    key_valid = v;
    key_code  = c;
    if (scan_on) begin
      keyPad_row = ~(4'b0001 << scan_ph[3:2]);
      scan_ph    = scan_ph + 4'd1;
    end else begin
      keyPad_row = 4'b1111;
    end
    if (force_en) begin
      keyPad_row = force_row;
    end else if (bad_rate != 0 && keyPad_row != 4'b1110 && $urandom_range(0, bad_rate - 1) == 0) begin
      keyPad_row = 4'b1100;
    end
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_outputs();
  endtask

  task automatic run_idle(input int bound, input string tag);
    int n;
    n = 0;
    do begin
      cycle(1'b0, 4'h0);
      n++;
    end while ((m_active || m_fifo.size() > 0) && n < bound);
    chk_int(tag, int'(n < bound), 1);
  endtask

  task automatic clear_obs();
    obs_done = 0;
    obs_terr = 0;
    obs_col  = 0;
    seen_0   = 1'b0;
    seen_f   = 1'b0;
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    keyPad_row = 4'hF;
    scan_on   = 1'b0;
    scan_ph   = 4'd0;
    bad_rate  = 0;
    force_en  = 1'b0;
    force_row = 4'hF;
    m_active  = 1'b0;
    m_starts  = 0;
    m_idle    = 0;
    m_cur     = 4'h0;
    m_r1      = 4'hF;
    m_r2      = 4'hF;
    m_done    = 1'b0;
    m_terr    = 1'b0;
    clear_obs();

    // Reset state
    cycle(1'b0, 4'h0);
    cycle(1'b0, 4'h0);
    reset = 1'b0;
    chk("rst_ready", {3'b000, key_ready}, 4'h1);
    chk("rst_busy", {3'b000, busy}, 4'h0);
    chk("rst_col", keyPad_col, 4'hF);
    cycle(1'b0, 4'h0);

    // Basic press of key 0110: 3 rounds of column 1011 on row 1101, one done
    clear_obs();
    scan_on = 1'b1;
    scan_ph = 4'd0;
    cycle(1'b1, 4'h6);
    run_idle(300, "basic_bound");
    chk_int("basic_done_cnt", obs_done, 1);
    chk_int("basic_col_cycles", obs_col, 12);
    chk_int("basic_terr_cnt", obs_terr, 0);

    // Sequence order: key 0 then key F
    clear_obs();
    cycle(1'b1, 4'h0);
    cycle(1'b1, 4'hF);
    run_idle(400, "seq_bound");
    chk_int("seq_done_cnt", obs_done, 2);
    chk_int("seq_key0_seen", int'(seen_0), 1);
    chk_int("seq_keyf_seen", int'(seen_f), 1);

    // FIFO full with scanner stopped: one key held in ARM, four queued, fifth dropped
    clear_obs();
    scan_on = 1'b0;
    cycle(1'b1, 4'h1);
    cycle(1'b0, 4'h0);
    cycle(1'b1, 4'h2);
    cycle(1'b1, 4'h3);
    cycle(1'b1, 4'h4);
    cycle(1'b1, 4'h5);
    chk("full_ready", {3'b000, key_ready}, 4'h0);
    cycle(1'b1, 4'h6);
    chk("full_busy", {3'b000, busy}, 4'h1);
    chk("full_ready_after", {3'b000, key_ready}, 4'h0);
    run_idle(800, "full_bound");
    chk_int("full_terr_cnt", obs_terr, 5);
    chk_int("full_done_cnt", obs_done, 0);

    // Timeout latency measured from ARM entry
    clear_obs();
    cycle(1'b1, 4'h9);
    cycle(1'b0, 4'h0);
    n = 0;
    do begin
      cycle(1'b0, 4'h0);
      n++;
    end while (timeout_err !== 1'b1 && n < 200);
    chk_int("tmo_latency", n, TMO);
    chk("tmo_busy", {3'b000, busy}, 4'h0);
    chk_int("tmo_done_cnt", obs_done, 0);

    // Reset in round 2 of a press while the key's row is driven
    clear_obs();
    scan_on = 1'b1;
    scan_ph = 4'd0;
    cycle(1'b1, 4'h6);
    n = 0;
    do begin
      cycle(1'b0, 4'h0);
      n++;
    end while (!(m_active && m_starts == 2 && scan_ph == 4'd5) && n < 300);
    chk_int("rstmid_reach", int'(n < 300), 1);
    chk("rstmid_pre_col", keyPad_col, 4'b1011);
    reset = 1'b1;
    cycle(1'b0, 4'h0);
    reset = 1'b0;
    chk("rstmid_col", keyPad_col, 4'hF);
    chk("rstmid_ready", {3'b000, key_ready}, 4'h1);
    chk("rstmid_busy", {3'b000, busy}, 4'h0);
    for (int i = 0; i < 120; i++) cycle(1'b0, 4'h0);
    chk_int("rstmid_done_cnt", obs_done, 0);

    // Non-one-cold row during PRESS releases the column
    cycle(1'b1, 4'h6);
    n = 0;
    do begin
      cycle(1'b0, 4'h0);
      n++;
    end while (!(m_active && m_starts >= 1 && m_starts <= HOLD && scan_ph == 4'd5) && n < 300);
    chk("goodrow_col", keyPad_col, 4'b1011);
    force_en  = 1'b1;
    force_row = 4'b1100;
    cycle(1'b0, 4'h0);
    force_en  = 1'b0;
    chk("badrow_col", keyPad_col, 4'hF);
    run_idle(300, "badrow_bound");

    // Random traffic with occasional invalid rows
    bad_rate = 16;
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, 4'($urandom));
    end
    bad_rate = 0;
    run_idle(1000, "rand_bound");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
